// File: rtl/dcache_controller.sv
// Two-way set-associative, write-through, no-write-allocate data cache controller.
// Optional hit/miss counters are included when DCACHE_STATS_EN is defined.
module dcache_controller #(
  parameter int          INDEX_BITS = 6,
  parameter logic [31:0] DATA_BASE  = 32'd1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_r_en,
  input  logic        mem_w_en,
  input  logic [31:0] address,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        ready,
  output logic        sram_r_en,
  output logic        sram_w_en,
  output logic [31:0] sram_address,
  output logic [31:0] sram_wdata,
  input  logic [63:0] sram_rdata,
  input  logic        sram_ready,
`ifdef DCACHE_STATS_EN
  output logic [31:0] hit_count,
  output logic [31:0] miss_count,
`endif
  output logic        sram_hit
);

  localparam int SETS  = 1 << INDEX_BITS;
  localparam int TAG_W = 16 - INDEX_BITS;

  typedef enum logic [1:0] {IDLE, RD_MISS, WR} state_t;

  state_t state_q, state_d;

  logic [SETS-1:0]  valid0_q, valid1_q, lru_q;
  logic [TAG_W-1:0] tag0_q  [SETS];
  logic [TAG_W-1:0] tag1_q  [SETS];
  logic [63:0]      line0_q [SETS];
  logic [63:0]      line1_q [SETS];

  logic [31:0]           a;
  logic                  word_sel;
  logic [INDEX_BITS-1:0] idx;
  logic [TAG_W-1:0]      tag;
  logic                  hit0, hit1, victim;
  logic [63:0]           hit_line;
  logic [31:0]           hit_word, fill_word;
  logic                  fill_en, upd_en, touch;
  logic                  unused_addr_bits;

  assign a                = address - DATA_BASE;
  assign word_sel         = a[2];
  assign idx              = a[3 +: INDEX_BITS];
  assign tag              = a[18 : 3+INDEX_BITS];
  assign unused_addr_bits = ^{a[31:19], a[1:0]};

  assign hit0      = valid0_q[idx] && (tag0_q[idx] == tag);
  assign hit1      = valid1_q[idx] && (tag1_q[idx] == tag);
  assign hit_line  = hit1 ? line1_q[idx] : line0_q[idx];
  assign hit_word  = word_sel ? hit_line[63:32] : hit_line[31:0];
  assign fill_word = word_sel ? sram_rdata[63:32] : sram_rdata[31:0];

  // Prefer an empty way (way0 first); only evict by LRU when the set is full.
  assign victim = valid0_q[idx] ? (valid1_q[idx] ? lru_q[idx] : 1'b1) : 1'b0;

  assign sram_address = address;
  assign sram_wdata   = wdata;

  always_comb begin
    state_d   = state_q;
    ready     = 1'b1;
    rdata     = '0;
    sram_r_en = 1'b0;
    sram_w_en = 1'b0;
    sram_hit  = 1'b0;
    fill_en   = 1'b0;
    upd_en    = 1'b0;
    touch     = 1'b0;
    case (state_q)
      IDLE: begin
        if (mem_w_en) begin
          sram_w_en = 1'b1;
          ready     = 1'b0;
          state_d   = WR;
        end else if (mem_r_en) begin
          if (hit0 || hit1) begin
            rdata    = hit_word;
            sram_hit = 1'b1;
            touch    = 1'b1;
          end else begin
            sram_r_en = 1'b1;
            ready     = 1'b0;
            state_d   = RD_MISS;
          end
        end
      end
      RD_MISS: begin
        sram_r_en = 1'b1;
        ready     = 1'b0;
        if (sram_ready) begin
          ready   = 1'b1;
          rdata   = fill_word;
          fill_en = 1'b1;
          state_d = IDLE;
        end
      end
      WR: begin
        sram_w_en = 1'b1;
        ready     = 1'b0;
        if (sram_ready) begin
          ready   = 1'b1;
          upd_en  = hit0 || hit1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      valid0_q <= '0;
      valid1_q <= '0;
      lru_q    <= '0;
    end else begin
      state_q <= state_d;
      if (fill_en) begin
        if (victim) valid1_q[idx] <= 1'b1;
        else        valid0_q[idx] <= 1'b1;
        lru_q[idx] <= ~victim;
      end
      // A hit on way0 makes way1 the least recently used, and vice versa.
      if (touch || upd_en) lru_q[idx] <= hit0;
    end
  end

  always_ff @(posedge clk) begin
    if (fill_en) begin
      if (victim) begin
        tag1_q[idx]  <= tag;
        line1_q[idx] <= sram_rdata;
      end else begin
        tag0_q[idx]  <= tag;
        line0_q[idx] <= sram_rdata;
      end
    end
    if (upd_en) begin
      if (hit1) begin
        if (word_sel) line1_q[idx][63:32] <= wdata;
        else          line1_q[idx][31:0]  <= wdata;
      end else begin
        if (word_sel) line0_q[idx][63:32] <= wdata;
        else          line0_q[idx][31:0]  <= wdata;
      end
    end
  end

`ifdef DCACHE_STATS_EN
  logic [31:0] hit_count_q, miss_count_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      hit_count_q  <= '0;
      miss_count_q <= '0;
    end else begin
      if (touch)   hit_count_q  <= hit_count_q + 32'd1;
      if (fill_en) miss_count_q <= miss_count_q + 32'd1;
    end
  end

  assign hit_count  = hit_count_q;
  assign miss_count = miss_count_q;
`endif

endmodule

// File: tb/tb_dcache_controller.sv
// Scoreboard bench for dcache_controller with a latency-6 SRAM model.
module tb_dcache_controller;

  localparam int LAT = 6;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_r_en, mem_w_en;
  logic [31:0] address, wdata, rdata;
  logic        ready, sram_r_en, sram_w_en, sram_hit;
  logic [31:0] sram_address, sram_wdata;
  logic [63:0] sram_rdata;
  bit          sram_ready;
`ifdef DCACHE_STATS_EN
  logic [31:0] hit_count, miss_count;
`endif

  always #5 clk = ~clk;

  dcache_controller dut (
    .clk          (clk),
    .rst          (rst),
    .mem_r_en     (mem_r_en),
    .mem_w_en     (mem_w_en),
    .address      (address),
    .wdata        (wdata),
    .rdata        (rdata),
    .ready        (ready),
    .sram_r_en    (sram_r_en),
    .sram_w_en    (sram_w_en),
    .sram_address (sram_address),
    .sram_wdata   (sram_wdata),
    .sram_rdata   (sram_rdata),
    .sram_ready   (sram_ready),
`ifdef DCACHE_STATS_EN
    .hit_count    (hit_count),
    .miss_count   (miss_count),
`endif
    .sram_hit     (sram_hit)
  );

  // SRAM model: word memory covering byte addresses 0..4095, fixed latency.
  logic [31:0] smem [1024];
  bit          init_done;
  int          cnt;

  assign sram_rdata = {smem[{sram_address[11:3], 1'b1}], smem[{sram_address[11:3], 1'b0}]};

  always @(posedge clk) begin
    if (!init_done) begin
      for (int i = 0; i < 1024; i++)
        smem[i] <= (i == 256) ? 32'hAAAA : (i == 257) ? 32'hBBBB : (32'h5A000000 | i);
      init_done <= 1'b1;
    end else if (sram_w_en && sram_ready) begin
      smem[sram_address[11:2]] <= sram_wdata;
    end
    if ((sram_r_en || sram_w_en) && !sram_ready) begin
      cnt        <= cnt + 1;
      sram_ready <= (cnt + 1 == LAT);
    end else begin
      cnt        <= 0;
      sram_ready <= 1'b0;
    end
  end

  int          total  = 0;
  int          passed = 0;
  logic [31:0] exp_q[$];

  function automatic logic [31:0] exp_word(input logic [31:0] a);
    return 32'h5A000000 | {22'd0, a[11:2]};
  endfunction

  // Drivers: start at posedge+1, return at posedge+1 after the completion edge.
  task automatic drive_read(input logic [31:0] a, output logic [31:0] rd,
                            output int waits, output logic hitflag);
    mem_r_en = 1'b1;
    address  = a;
    waits    = 0;
    @(negedge clk);
    while (!ready && waits < 200) begin
      waits++;
      @(negedge clk);
    end
    rd      = rdata;
    hitflag = sram_hit;
    @(posedge clk);
    #1;
    mem_r_en = 1'b0;
  endtask

  task automatic drive_write(input logic [31:0] a, input logic [31:0] d,
                             output int waits, output int wen_cycles);
    mem_w_en   = 1'b1;
    address    = a;
    wdata      = d;
    waits      = 0;
    wen_cycles = 0;
    @(negedge clk);
    if (sram_w_en) wen_cycles++;
    while (!ready && waits < 200) begin
      waits++;
      @(negedge clk);
      if (sram_w_en) wen_cycles++;
    end
    @(posedge clk);
    #1;
    mem_w_en = 1'b0;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    mem_r_en = 1'b0;
    mem_w_en = 1'b0;
    address  = 32'd0;
    wdata    = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
    @(negedge clk);
    total++; if (ready !== 1'b1) $display("FAIL reset_ready: got %b expected 1", ready); else passed++;
    total++; if (rdata !== 32'd0) $display("FAIL reset_rdata: got %h expected 0", rdata); else passed++;
    total++; if (sram_r_en !== 1'b0) $display("FAIL reset_sram_r_en: got %b expected 0", sram_r_en); else passed++;
    total++; if (sram_w_en !== 1'b0) $display("FAIL reset_sram_w_en: got %b expected 0", sram_w_en); else passed++;
    total++; if (sram_hit !== 1'b0) $display("FAIL reset_sram_hit: got %b expected 0", sram_hit); else passed++;
  endtask

  task automatic test_miss_then_hit();
    logic [31:0] rd, e;
    int w;
    logic h;
    @(posedge clk); #1;
    exp_q.push_back(32'hAAAA);
    drive_read(32'd1024, rd, w, h);
    e = exp_q.pop_front();
    total++; if (rd !== e) $display("FAIL miss_rdata: got %h expected %h", rd, e); else passed++;
    total++; if (w !== LAT) $display("FAIL miss_wait: got %0d expected %0d", w, LAT); else passed++;
    exp_q.push_back(32'hBBBB);
    drive_read(32'd1028, rd, w, h);
    e = exp_q.pop_front();
    total++; if (rd !== e) $display("FAIL hit_rdata: got %h expected %h", rd, e); else passed++;
    total++; if (w !== 0) $display("FAIL hit_wait: got %0d expected 0", w); else passed++;
    total++; if (h !== 1'b1) $display("FAIL hit_sram_hit: got %b expected 1", h); else passed++;
  endtask

  task automatic test_eviction();
    logic [31:0] addrs [6] = '{32'd1024, 32'd1536, 32'd1024, 32'd2048, 32'd1024, 32'd1536};
    int          waitx [6] = '{0, LAT, 0, LAT, 0, LAT};
    logic [31:0] rd, e;
    int w;
    logic h;
    @(posedge clk); #1;
    for (int i = 0; i < 6; i++) begin
      exp_q.push_back((addrs[i] == 32'd1024) ? 32'hAAAA : exp_word(addrs[i]));
      drive_read(addrs[i], rd, w, h);
      e = exp_q.pop_front();
      total++; if (rd !== e) $display("FAIL evict_rdata step %0d: got %h expected %h", i, rd, e); else passed++;
      total++; if (w !== waitx[i]) $display("FAIL evict_wait step %0d: got %0d expected %0d", i, w, waitx[i]); else passed++;
    end
  endtask

  task automatic test_store_hit();
    logic [31:0] rd, e;
    int w, wen;
    logic h;
    @(posedge clk); #1;
    drive_write(32'd1028, 32'h1234, w, wen);
    total++; if (w !== LAT) $display("FAIL store_hit_wait: got %0d expected %0d", w, LAT); else passed++;
    total++; if (wen !== LAT + 1) $display("FAIL store_hit_wen_cycles: got %0d expected %0d", wen, LAT + 1); else passed++;
    exp_q.push_back(32'h1234);
    exp_q.push_back(32'hAAAA);
    drive_read(32'd1028, rd, w, h);
    e = exp_q.pop_front();
    total++; if (rd !== e) $display("FAIL store_hit_rdata: got %h expected %h", rd, e); else passed++;
    total++; if (w !== 0) $display("FAIL store_hit_reload_wait: got %0d expected 0", w); else passed++;
    drive_read(32'd1024, rd, w, h);
    e = exp_q.pop_front();
    total++; if (rd !== e) $display("FAIL store_hit_other_word: got %h expected %h", rd, e); else passed++;
    total++; if (w !== 0) $display("FAIL store_hit_other_wait: got %0d expected 0", w); else passed++;
  endtask

  task automatic test_store_miss();
    logic [31:0] rd, e;
    int w, wen;
    logic h;
    apply_reset();
    @(posedge clk); #1;
    drive_write(32'd2048, 32'hCAFE, w, wen);
    total++; if (w !== LAT) $display("FAIL store_miss_wait: got %0d expected %0d", w, LAT); else passed++;
    total++; if (wen !== LAT + 1) $display("FAIL store_miss_wen_cycles: got %0d expected %0d", wen, LAT + 1); else passed++;
    exp_q.push_back(32'hCAFE);
    drive_read(32'd2048, rd, w, h);
    e = exp_q.pop_front();
    total++; if (rd !== e) $display("FAIL store_miss_rdata: got %h expected %h", rd, e); else passed++;
    total++; if (w !== LAT) $display("FAIL store_miss_reload_wait: got %0d expected %0d", w, LAT); else passed++;
  endtask

  task automatic test_reset_mid_miss();
    logic [31:0] rd, e;
    int w;
    logic h;
    @(posedge clk); #1;
    mem_r_en = 1'b1;
    address  = 32'd2560;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst      = 1'b1;
    mem_r_en = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    total++; if (sram_r_en !== 1'b0) $display("FAIL rst_miss_sram_r_en: got %b expected 0", sram_r_en); else passed++;
    total++; if (ready !== 1'b1) $display("FAIL rst_miss_ready: got %b expected 1", ready); else passed++;
    @(posedge clk); #1;
    exp_q.push_back(exp_word(32'd2560));
    drive_read(32'd2560, rd, w, h);
    e = exp_q.pop_front();
    total++; if (rd !== e) $display("FAIL rst_miss_rdata: got %h expected %h", rd, e); else passed++;
    total++; if (w !== LAT) $display("FAIL rst_miss_reload_wait: got %0d expected %0d", w, LAT); else passed++;
    exp_q.push_back(32'hCAFE);
    drive_read(32'd2048, rd, w, h);
    e = exp_q.pop_front();
    total++; if (rd !== e) $display("FAIL rst_invalidate_rdata: got %h expected %h", rd, e); else passed++;
    total++; if (w !== LAT) $display("FAIL rst_invalidate_wait: got %0d expected %0d", w, LAT); else passed++;
  endtask

`ifdef DCACHE_STATS_EN
  task automatic test_stats();
    logic [31:0] seq [4] = '{32'd3072, 32'd3072, 32'd3076, 32'd3072};
    logic [31:0] rd, e;
    int w;
    logic h;
    apply_reset();
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(exp_word(seq[i]));
      drive_read(seq[i], rd, w, h);
      e = exp_q.pop_front();
      total++; if (rd !== e) $display("FAIL stats_rdata step %0d: got %h expected %h", i, rd, e); else passed++;
    end
    total++; if (miss_count !== 32'd1) $display("FAIL stats_miss_count: got %0d expected 1", miss_count); else passed++;
    total++; if (hit_count !== 32'd3) $display("FAIL stats_hit_count: got %0d expected 3", hit_count); else passed++;
  endtask
`endif

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_miss_then_hit();
    test_eviction();
    test_store_hit();
    test_store_miss();
    test_reset_mid_miss();
`ifdef DCACHE_STATS_EN
    test_stats();
`endif
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
